// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, group-count helper and group P/G pair type for the CLA adder.
package cla_pkg;
  localparam int GROUP_W = 4;
  typedef struct packed {
    logic p;
    logic g;
  } grp_pg_t;
  function automatic int n_groups(input int width);
    return width / GROUP_W;
  endfunction
endpackage

// File: rtl/cla_group.sv
// cla_group: 4-bit lookahead cell producing group P/G and the four carries entering each bit.
module cla_group
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] p_i,
  input  logic [GROUP_W-1:0] g_i,
  input  logic               c_i,
  output grp_pg_t            pg_o,
  output logic [GROUP_W-1:0] c_o
);
  assign c_o[0] = c_i;
  assign c_o[1] = g_i[0] | (p_i[0] & c_i);
  assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
  assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                | (p_i[2] & p_i[1] & p_i[0] & c_i);
  assign pg_o.p = &p_i;
  assign pg_o.g = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage valid/ready add/subtract unit; stage 1 latches p/g/cin, stage 2
// resolves carries with two-level lookahead and produces sum and flags.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NG = n_groups(WIDTH);
  if (WIDTH % GROUP_W != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a multiple of 4 in 4..64");
  end
  logic             v1_q, v1_d, c1_q, c_d, acc, adv1, drain;
  logic [WIDTH-1:0] p1_q, g1_q, p_d, g_d, sum_d;
  logic             cout_d, ovf_d, zero_d;
  logic [WIDTH:0]   c;
  logic [NG:0]      gc;
  logic [NG-1:0]    gp_v, gg_v;
  grp_pg_t [NG-1:0] grp;
  assign adv1     = v1_q & drain;
  assign in_ready = ~rst & (~v1_q | adv1);
  assign acc      = in_valid & in_ready;
  always_comb begin
    p_d  = a ^ (b ^ {WIDTH{sub}});
    g_d  = a & (b ^ {WIDTH{sub}});
    c_d  = sub | cin;
    v1_d = in_ready ? in_valid : v1_q;
  end
  always_ff @(posedge clk) begin
    v1_q <= rst ? 1'b0 : v1_d;
    if (acc) begin
      p1_q <= p_d;
      g1_q <= g_d;
      c1_q <= c_d;
    end
  end
  for (genvar j = 0; j < NG; j++) begin : g_lvl1
    cla_group u_grp (
      .p_i (p1_q[GROUP_W*j +: GROUP_W]),
      .g_i (g1_q[GROUP_W*j +: GROUP_W]),
      .c_i (gc[j]),
      .pg_o(grp[j]),
      .c_o (c[GROUP_W*j +: GROUP_W])
    );
    assign gp_v[j] = grp[j].p;
    assign gg_v[j] = grp[j].g;
  end
  if (NG <= 4) begin : g_lvl2_cell
    // Unused upper slots propagate and never generate, so the cell's P/G cover only real groups.
    grp_pg_t    l2;
    logic [3:0] lc;
    cla_group u_lvl2 (
      .p_i (~4'(~gp_v)),
      .g_i (4'(gg_v)),
      .c_i (c1_q),
      .pg_o(l2),
      .c_o (lc)
    );
    assign gc = {l2.g | (l2.p & c1_q), lc[NG-1:0]};
  end else begin : g_lvl2_wide
    function automatic logic [NG-1:0] span(input int lo, input int hi);
      logic [NG-1:0] m;
      for (int i = 0; i < NG; i++) m[i] = (i >= lo) && (i <= hi);
      return m;
    endfunction
    // Each group carry-in is a flat sum of products over all lower groups.
    always_comb begin
      gc    = '0;
      gc[0] = c1_q;
      for (int j = 0; j < NG; j++) begin
        gc[j+1] = c1_q & (&(gp_v | ~span(0, j)));
        for (int k = 0; k <= j; k++)
          gc[j+1] = gc[j+1] | (gg_v[k] & (&(gp_v | ~span(k + 1, j))));
      end
    end
  end
  assign c[WIDTH] = gc[NG];
  always_comb begin
    sum_d  = p1_q ^ c[WIDTH-1:0];
    cout_d = c[WIDTH];
    ovf_d  = c[WIDTH] ^ c[WIDTH-1];
    zero_d = ~|sum_d;
  end
  if (OUT_REG) begin : g_oreg
    logic             v2_q, cout_q, ovf_q, zero_q;
    logic [WIDTH-1:0] sum_q;
    assign drain = ~v2_q | out_ready;
    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q   <= 1'b0;
        sum_q  <= '0;
        cout_q <= 1'b0;
        ovf_q  <= 1'b0;
        zero_q <= 1'b0;
      end else begin
        if (drain) v2_q <= v1_q;
        if (adv1) begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
    assign out_valid = v2_q & ~rst;
    assign sum       = rst ? '0 : sum_q;
    assign cout      = cout_q & ~rst;
    assign ovf       = ovf_q & ~rst;
    assign zero      = zero_q & ~rst;
  end else begin : g_ocomb
    assign drain     = out_ready;
    assign out_valid = v1_q & ~rst;
    assign sum       = rst ? '0 : sum_d;
    assign cout      = cout_d & ~rst;
    assign ovf       = ovf_d & ~rst;
    assign zero      = zero_d & ~rst;
  end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: directed and randomized checks of cla_adder_pipe (WIDTH=16, OUT_REG=1).
module tb_cla_adder_pipe;
  localparam int W = 16;
  localparam int N = 10000;
  logic clk = 0, rst = 1, in_valid = 0, cin = 0, sub = 0, out_ready = 0;
  logic in_ready, out_valid, cout, ovf, zero;
  logic [W-1:0] a = '0, b = '0, sum;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  cla_adder_pipe #(.WIDTH(W), .OUT_REG(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, mb, input logic mc, ms);
    int ua, ub, r, sr;
    logic [W-1:0] s;
    logic co, ov;
    ua = int'(ma);
    ub = int'(mb);
    if (ms) begin
      r  = ua - ub;
      co = ua >= ub;
      sr = int'(signed'(ma)) - int'(signed'(mb));
    end else begin
      r  = ua + ub + int'(mc);
      co = r > 65535;
      sr = int'(signed'(ma)) + int'(signed'(mb)) + int'(mc);
    end
    s  = r[W-1:0];
    ov = sr > 32767 || sr < -32768;
    return {s, co, ov, s == '0};
  endfunction
  function automatic logic [W-1:0] pick();
    int r;
    r = int'($urandom_range(0, 7));
    return r == 0 ? 16'h0000 : r == 1 ? 16'hFFFF : r == 2 ? 16'h7FFF : r == 3 ? 16'h8000 : W'($urandom);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_one(input logic [W-1:0] ta, tb, input logic tc, ts);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
  endtask
  task automatic test_reset();
    rst = 1; in_valid = 1; a = '1; b = '1;
    repeat (3) tick();
    #1 checks++;
    if ({in_ready, out_valid, sum, cout, ovf, zero} !== '0)
      begin errors++; $display("FAIL reset_state got %h exp 0", {in_ready, out_valid, sum, cout, ovf, zero}); end
    in_valid = 0;
    tick();
    rst = 0;
    #1 checks++;
    if ({in_ready, out_valid} !== 2'b10)
      begin errors++; $display("FAIL reset_release got %b exp 10", {in_ready, out_valid}); end
  endtask
  task automatic test_add();
    send_one(16'hFFFF, 16'h0001, 0, 0);
    #1 checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency_early got %b exp 0", out_valid); end
    tick();
    #1 checks++;
    if ({out_valid, sum, cout, ovf, zero} !== {1'b1, 16'h0000, 3'b101})
      begin errors++; $display("FAIL add_wrap got %h exp %h", {out_valid, sum, cout, ovf, zero}, {1'b1, 16'h0000, 3'b101}); end
    tick();
    send_one(16'h7FFF, 16'h0001, 0, 0);
    tick();
    #1 checks++;
    if ({out_valid, sum, cout, ovf, zero} !== {1'b1, 16'h8000, 3'b010})
      begin errors++; $display("FAIL add_ovf got %h exp %h", {out_valid, sum, cout, ovf, zero}, {1'b1, 16'h8000, 3'b010}); end
    tick();
  endtask
  task automatic test_sub();
    send_one(16'h0005, 16'h0007, 1, 1);
    tick();
    #1 checks++;
    if ({out_valid, sum, cout, ovf, zero} !== {1'b1, 16'hFFFE, 3'b000})
      begin errors++; $display("FAIL sub_borrow got %h exp %h", {out_valid, sum, cout, ovf, zero}, {1'b1, 16'hFFFE, 3'b000}); end
    tick();
    send_one(16'h8000, 16'h0001, 0, 1);
    tick();
    #1 checks++;
    if ({out_valid, sum, cout, ovf, zero} !== {1'b1, 16'h7FFF, 3'b110})
      begin errors++; $display("FAIL sub_ovf got %h exp %h", {out_valid, sum, cout, ovf, zero}, {1'b1, 16'h7FFF, 3'b110}); end
    tick();
  endtask
  task automatic test_backpressure();
    logic [W-1:0] ba[4], bb[4];
    logic [W+2:0] ex[4];
    int idx = 0, ri = 0, gap = 0;
    for (int i = 0; i < 4; i++) begin
      ba[i] = W'($urandom); bb[i] = W'($urandom);
      ex[i] = model(ba[i], bb[i], 1'b0, i[0]);
    end
    out_ready = 0; cin = 0;
    repeat (6) begin
      in_valid = idx < 4;
      if (idx < 4) begin a = ba[idx]; b = bb[idx]; sub = idx[0]; end
      #1;
      if (out_valid) begin
        checks++;
        if ({sum, cout, ovf, zero} !== ex[0])
          begin errors++; $display("FAIL bp_hold got %h exp %h", {sum, cout, ovf, zero}, ex[0]); end
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    #1 checks++;
    if (idx !== 2 || in_ready !== 1'b0)
      begin errors++; $display("FAIL bp_accept got %0d/%b exp 2/0", idx, in_ready); end
    out_ready = 1;
    repeat (10) begin
      in_valid = idx < 4;
      if (idx < 4) begin a = ba[idx]; b = bb[idx]; sub = idx[0]; end
      #1;
      if (out_valid) begin
        checks++;
        if (ri >= 4) begin errors++; $display("FAIL bp_extra got result %0d exp none", ri); end
        else if ({sum, cout, ovf, zero} !== ex[ri])
          begin errors++; $display("FAIL bp_order[%0d] got %h exp %h", ri, {sum, cout, ovf, zero}, ex[ri]); end
        ri++;
      end else if (ri > 0 && ri < 4) gap++;
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 0;
    checks++;
    if (ri !== 4 || gap !== 0)
      begin errors++; $display("FAIL bp_drain got %0d results %0d gaps exp 4 results 0 gaps", ri, gap); end
  endtask
  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 0;
    repeat (2) begin
      a = W'($urandom) | 16'h1; b = W'($urandom); cin = 1; sub = 0; in_valid = 1;
      tick();
    end
    in_valid = 0; rst = 1;
    #1 checks++;
    if ({in_ready, out_valid, sum, cout, ovf, zero} !== '0)
      begin errors++; $display("FAIL rst_mid_outputs got %h exp 0", {in_ready, out_valid, sum, cout, ovf, zero}); end
    tick();
    rst = 0;
    #1 checks++;
    if ({in_ready, out_valid} !== 2'b10)
      begin errors++; $display("FAIL rst_mid_release got %b exp 10", {in_ready, out_valid}); end
    out_ready = 1;
    repeat (5) begin
      #1 if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_stale got %0d results exp 0", seen); end
  endtask
  task automatic test_random();
    logic [W+2:0] q[$];
    int sent = 0, cyc = 0;
    while ((sent < N || q.size() > 0) && cyc < 60000) begin
      in_valid  = sent < N && $urandom_range(0, 3) != 0;
      a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rand_unexpected got %h exp none", {sum, cout, ovf, zero}); end
        else begin
          if ({sum, cout, ovf, zero} !== q[0])
            begin errors++; $display("FAIL rand_result got %h exp %h", {sum, cout, ovf, zero}, q[0]); end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin q.push_back(model(a, b, cin, sub)); sent++; end
      tick();
      cyc++;
    end
    in_valid = 0;
    checks++;
    if (sent != N || q.size() != 0)
      begin errors++; $display("FAIL rand_complete got %0d sent %0d pending exp %0d sent 0 pending", sent, q.size(), N); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_adder_pipe.md
CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 32, is the operand width; it SHALL be a multiple of 4, from 4 to 64 inclusive.
REQ-002 Parameter OUT_REG, default 1, SHALL register the sum outputs when 1; when 0, stage 2 is combinational from stage 1.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port in_valid, input, 1 bit: operand beat present.
REQ-006 Port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-007 Port a, input, WIDTH bits: operand A.
REQ-008 Port b, input, WIDTH bits: operand B.
REQ-009 Port cin, input, 1 bit: carry-in; ignored when sub=1.
REQ-010 Port sub, input, 1 bit: 0 = add, 1 = subtract (A - B).
REQ-011 Port out_valid, output, 1 bit: result present.
REQ-012 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 Port sum, output, WIDTH bits: result.
REQ-014 Port cout, output, 1 bit: carry out of the MSB.
REQ-015 Port ovf, output, 1 bit: two's-complement signed overflow.
REQ-016 Port zero, output, 1 bit: sum == 0.

Function
REQ-017 The block SHALL compute effective B as b XOR {WIDTH{sub}} and effective carry-in as sub ? 1 : cin.
REQ-018 Bit signals SHALL be p[i] = a[i] XOR b_eff[i] and g[i] = a[i] AND b_eff[i].
REQ-019 Carries SHALL use two-level lookahead, never ripple:
  - level 1: per 4-bit group, group P/G and intra-group carries;
  - level 2: lookahead across groups for the group carry-ins.
REQ-020 Stage 1 SHALL register p, g, and effective carry-in on a handshake beat (in_valid and in_ready both high); stage 2 SHALL compute carries, sum, and flags.
REQ-021 Latency SHALL be 2 cycles (accept-to-out_valid) when OUT_REG=1 and 1 cycle when OUT_REG=0, with no backpressure.
REQ-022 Throughput SHALL be one beat per cycle while out_ready is high.
REQ-023 sum[i] SHALL equal p[i] XOR c[i]; cout SHALL equal c[WIDTH].
REQ-024 ovf SHALL equal c[WIDTH] XOR c[WIDTH-1].
REQ-025 In subtract mode, cout=1 SHALL mean "no borrow".
REQ-026 Each stage SHALL advance when its downstream register is empty or is being drained in the same cycle.
REQ-027 in_ready SHALL be high when stage 1 is empty or will advance this cycle (a combinational path from out_ready is permitted).
REQ-028 While out_valid=1 and out_ready=0, sum, cout, ovf, and zero SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-029 Results SHALL leave in acceptance order.
REQ-030 A beat accepted in the same cycle the output drains SHALL be handled as a simultaneous push/pop with no bubble.
REQ-031 When in_valid=1 and in_ready=0, the block SHALL ignore a, b, cin, and sub.

Reset
REQ-032 While rst=1, all valid flags SHALL clear, and out_valid, sum, cout, ovf, and zero SHALL read 0.
REQ-033 in_ready SHALL read 0 during reset and 1 in the first cycle after rst falls.
REQ-034 Reset mid-operation SHALL discard in-flight beats; no result of a beat accepted before reset SHALL appear afterwards.
REQ-035 Data registers need no reset; only valid flags and visible outputs SHALL be reset.

Structure
REQ-036 A shared package cla_pkg SHALL hold:
  - the GROUP_W = 4 constant;
  - a function for the group count, WIDTH/GROUP_W;
  - a typedef for a group P/G pair.
REQ-037 A sub-module cla_group SHALL generate group P, group G, and 4 carries from 4-bit p/g plus carry-in; it SHALL be instantiated WIDTH/4 times at level 1 and reused for level 2 where the group count allows.
REQ-038 Elaboration SHALL fail on WIDTH not a multiple of 4 or out of range.

Verification (WIDTH=16, OUT_REG=1)
REQ-039 Add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, zero=1, out_valid exactly 2 cycles after accept.
REQ-040 Add 0x7FFF + 0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1, zero=0.
REQ-041 Subtract 0x0005 - 0x0007 -> sum=0xFFFE, cout=0 (borrow), ovf=0; subtract 0x8000 - 0x0001 -> sum=0x7FFF, ovf=1, cout=1.
REQ-042 Backpressure: offer 4 back-to-back beats with out_ready=0 for 6 cycles -> in_ready drops after 2 beats are accepted, outputs stay stable, then all 4 results emerge in order with no gap once out_ready=1.
REQ-043 Reset mid-operation: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and outputs 0 during reset, in_ready=1 the next cycle, neither old result appears.
REQ-044 Random: 10,000 random a/b/cin/sub beats with random out_ready -> each result matches an integer reference model (sum, cout, ovf, zero), in order.
